// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and the load/store path (LS). Each access walks IDLE -> REQ -> RESP with a
// single transaction outstanding, and the response is routed back to the
// requester that owns it. A watchdog aborts accesses that stall too long.
// Optional build macro MEM_ARB_RR_EN: round-robin tie-break between IF and LS
// instead of fixed LS-over-IF priority.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [2:0]        ls_op_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [2:0]        mem_op_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [2:0]      OP_WORD = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

    state_t             state, state_next;
    owner_t             owner;
    logic               we_q;
    logic [2:0]         op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CNT_W-1:0]   cnt;

    logic               grant_if, grant_ls, capture;
    logic               timeout, done, resp_valid;
    logic [DATA_W-1:0]  resp_data;

`ifdef MEM_ARB_RR_EN
    owner_t             last_owner;
`endif

    // Requester selection while idle; the winner's grant is a same-cycle pulse
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (if_req_i && ls_req_i) begin
                if (last_owner == OWN_LS) grant_if = 1'b1;
                else                      grant_ls = 1'b1;
            end else begin
                grant_if = if_req_i;
                grant_ls = ls_req_i;
            end
`else
            grant_ls = ls_req_i;
            grant_if = if_req_i & ~ls_req_i;
`endif
        end
    end

    assign capture = grant_if | grant_ls;
    assign timeout = (state != IDLE) && (cnt == CNT_MAX);
    assign done    = (state == RESP) && mem_rvalid_i;

    // Next-state logic; a response arriving with the timeout counts as completion
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (capture) state_next = REQ;
            REQ: begin
                if (timeout)        state_next = IDLE;
                else if (mem_gnt_i) state_next = RESP;
            end
            RESP: if (done || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side request and requester-side response outputs
    always_comb begin
        mem_req_o   = (state == REQ) && !timeout;
        mem_we_o    = mem_req_o ? we_q : 1'b0;
        mem_op_o    = mem_req_o ? op_q : 3'b000;
        mem_addr_o  = mem_req_o ? addr_q : '0;
        mem_wdata_o = mem_req_o ? wdata_q : '0;
        resp_valid  = done | timeout;
        resp_data   = done ? mem_rdata_i : '0;
        err_o       = timeout & ~done;
        if_rvalid_o = resp_valid && (owner == OWN_IF);
        ls_rvalid_o = resp_valid && (owner == OWN_LS);
        if_rdata_o  = if_rvalid_o ? resp_data : '0;
        ls_rdata_o  = ls_rvalid_o ? resp_data : '0;
        if_gnt_o    = grant_if;
        ls_gnt_o    = grant_ls;
        busy_o      = (state != IDLE);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // Capture the winning request; IF accesses are always word reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner   <= OWN_IF;
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            owner   <= grant_ls ? OWN_LS : OWN_IF;
            we_q    <= grant_ls ? ls_we_i : 1'b0;
            op_q    <= grant_ls ? ls_op_i : OP_WORD;
            addr_q  <= grant_ls ? ls_addr_i : if_addr_i;
            wdata_q <= grant_ls ? ls_wdata_i : '0;
        end
    end

    // Watchdog: zero while idle, counts every busy cycle, saturates at the limit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               cnt <= '0;
        else if (state == IDLE)    cnt <= '0;
        else if (cnt != CNT_MAX)   cnt <= cnt + CNT_W'(1);
    end

`ifdef MEM_ARB_RR_EN
    // Remember the last owner so the other requester wins the next tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      last_owner <= OWN_LS;
        else if (capture) last_owner <= grant_ls ? OWN_LS : OWN_IF;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter.
// Each access is predicted from its grant delay and response delay: the
// watchdog outcome and the cycle of completion follow from simple arithmetic.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [2:0]  ls_op;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, err;

    int compare_count = 0;
    int fail_count    = 0;
`ifdef MEM_ARB_RR_EN
    bit last_ls = 1'b1;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_op_i(ls_op),
        .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt),
        .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_op_o(mem_op),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compare_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One idle cycle with stray memory handshakes that must be ignored
    task automatic idleCycle();
        mem_gnt    = 1'($urandom);
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        #4;
        checkOutput("stray_rvalid", 128'({if_rvalid, ls_rvalid, err}), 128'(0));
        checkOutput("stray_busy", 128'({busy, mem_req, if_gnt, ls_gnt}), 128'(0));
    endtask

    // Run one access: requests are already driven at posedge+1 of the capture
    // cycle. g = REQ cycles before the memory grants, r = RESP cycles before
    // the memory answers. Returns at the middle of the final cycle.
    task automatic applyStimulus(input int g, input int r, input logic [31:0] rsp_word,
                                 input bit allow_drop);
        bit          win_ls, timed_out, in_req, is_end, loser_ls;
        logic [67:0] exp_fields;
        int          end_c;
        logic        o_rv, n_rv;
        logic [31:0] o_rd, n_rd;

`ifdef MEM_ARB_RR_EN
        win_ls = (if_req && ls_req) ? !last_ls : ls_req;
        last_ls = win_ls;
`else
        win_ls = ls_req;
`endif
        loser_ls   = !win_ls;
        exp_fields = win_ls ? {ls_we, ls_op, ls_addr, ls_wdata} : {1'b0, 3'b010, if_addr, 32'h0};

        mem_gnt    = 1'b0;
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        #4;
        checkOutput("gnt_if", 128'(if_gnt), 128'(!win_ls));
        checkOutput("gnt_ls", 128'(ls_gnt), 128'(win_ls));
        checkOutput("idle_outputs", 128'({busy, mem_req, if_rvalid, ls_rvalid, err}), 128'(0));

        if (g >= TO) begin
            end_c = TO; timed_out = 1'b1;
        end else if (g + 1 + r <= TO) begin
            end_c = g + 1 + r; timed_out = 1'b0;
        end else begin
            end_c = TO; timed_out = 1'b1;
        end

        for (int c = 0; c <= end_c; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if (win_ls) begin
                    ls_req = 1'b0; ls_we = 1'($urandom); ls_op = 3'($urandom);
                    ls_addr = $urandom; ls_wdata = $urandom;
                end else begin
                    if_req = 1'b0; if_addr = $urandom;
                end
            end else if (allow_drop && ($urandom % 8 == 0)) begin
                if (loser_ls) ls_req = 1'b0;
                else          if_req = 1'b0;
            end
            in_req     = (c <= g);
            is_end     = (c == end_c);
            mem_gnt    = (c == g) ? 1'b1 : (in_req ? 1'b0 : 1'($urandom));
            mem_rvalid = in_req ? 1'($urandom) : (c == g + 1 + r);
            mem_rdata  = (c == g + 1 + r) ? rsp_word : $urandom;
            #4;
            o_rv = win_ls ? ls_rvalid : if_rvalid;
            o_rd = win_ls ? ls_rdata  : if_rdata;
            n_rv = win_ls ? if_rvalid : ls_rvalid;
            n_rd = win_ls ? if_rdata  : ls_rdata;
            checkOutput("busy", 128'(busy), 128'(1));
            checkOutput("grants_busy", 128'({if_gnt, ls_gnt}), 128'(0));
            checkOutput("mem_req", 128'(mem_req), 128'(in_req && !is_end));
            if (in_req && !is_end)
                checkOutput("mem_fields", 128'({mem_we, mem_op, mem_addr, mem_wdata}), 128'(exp_fields));
            checkOutput("owner_rvalid", 128'(o_rv), 128'(is_end));
            checkOutput("owner_rdata", 128'(o_rd), 128'((is_end && !timed_out) ? rsp_word : 32'h0));
            checkOutput("other_rvalid", 128'({n_rv, n_rd}), 128'(0));
            checkOutput("err", 128'(err), 128'(is_end && timed_out));
        end
    endtask

    // Asynchronous reset while an LS access waits in RESP
    task automatic resetMidAccess();
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_op = 3'b100; ls_addr = 32'h200; ls_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        ls_req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_mem_req", 128'({mem_req, busy}), 128'(0));
        checkOutput("rst_mid_rvalid", 128'({if_rvalid, ls_rvalid, err, ls_rdata}), 128'(0));
        @(negedge clk);
        mem_rvalid = 1'b0;
        rst_n = 1'b1;
`ifdef MEM_ARB_RR_EN
        last_ls = 1'b1;
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_op = '0; ls_addr = '0; ls_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        checkOutput("reset_ctrl", 128'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, mem_op, busy, err}), 128'(0));
        checkOutput("reset_data", 128'({if_rdata, ls_rdata, mem_addr, mem_wdata}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // IF fetch against a zero-latency memory
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0010;
        applyStimulus(0, 0, 32'h0000_0013, 1'b0);

        // Store with a grant delayed three cycles; ack lands on the watchdog limit
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b1; ls_op = 3'b000; ls_addr = 32'h100; ls_wdata = 32'hAB;
        applyStimulus(3, 0, 32'h0, 1'b0);

        // Tie between IF and LS, the loser keeps its request up
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        ls_req = 1'b1; ls_we = 1'b0; ls_op = 3'b010; ls_addr = 32'h0000_0300; ls_wdata = 32'h0;
        applyStimulus(0, 1, 32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1, 0, 32'h8765_4321, 1'b0);

        // Grant but no response, then no grant at all
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_op = 3'b001; ls_addr = 32'h0000_0404; ls_wdata = 32'h0;
        applyStimulus(0, 10, 32'h0, 1'b0);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        applyStimulus(6, 0, 32'h0, 1'b0);

        // Stray handshakes while idle, then a normal fetch
        @(posedge clk); #1;
        idleCycle();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0020;
        applyStimulus(0, 0, 32'hCAFE_0001, 1'b0);

        resetMidAccess();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0030;
        applyStimulus(1, 1, 32'hCAFE_0002, 1'b0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (if_req && ($urandom % 4 == 0)) if_req = 1'b0;
            if (ls_req && ($urandom % 4 == 0)) ls_req = 1'b0;
            if (!if_req && ($urandom % 2 == 1)) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!ls_req && ($urandom % 2 == 1)) begin
                ls_req = 1'b1; ls_we = 1'($urandom); ls_op = 3'($urandom);
                ls_addr = $urandom; ls_wdata = $urandom;
            end
            if (!if_req && !ls_req) idleCycle();
            else applyStimulus($urandom_range(0, 5), $urandom_range(0, 4), $urandom, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (IF) and the load/store path (LS).
- Sequences each access through request, grant and response phases with one outstanding transaction.
- Routes the response back to the owning requester.
- Sits between the core front end / LSU and the unified memory. Lets the core move off the ideal split-memory, zero-latency model.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT_CYC, 255, cycles allowed in REQ+RESP before the access is aborted; range 1..65535.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, held until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request captured (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DATA_W  fetch response data
- ls_req_i  in  1  load/store request, held until ls_gnt_o
- ls_we_i  in  1  1 = store
- ls_op_i  in  3  memory op, funct3 encoding (byte/half/word, signed/unsigned)
- ls_addr_i  in  ADDR_W  data address
- ls_wdata_i  in  DATA_W  store data
- ls_gnt_o  out  1  LS request captured (1-cycle pulse)
- ls_rvalid_o  out  1  LS response valid; stores also get one
- ls_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_op_o  out  3  memory op
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid (read data or write ack)
- mem_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  state != IDLE
- err_o  out  1  timeout abort pulse, asserted alongside the owner's rvalid

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, owner=IF, timeout counter=0.
  - All mem_* outputs 0; all gnt/rvalid/rdata 0; busy_o=0; err_o=0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Selects a requester; LS has fixed priority over IF.
  - Selected gnt_o is driven combinationally high in that cycle.
  - Captures we/op/addr/wdata into registers and records owner; next state is REQ.
  - IF captures force we=0, op=word (3'b010), wdata=0.
  - With no request, stays in IDLE.
- REQ:
  - mem_req_o=1; mem_we/op/addr/wdata driven from registers and held stable.
  - On mem_gnt_i=1, goes to RESP and drops mem_req_o the next cycle.
- RESP:
  - mem_req_o=0.
  - On mem_rvalid_i=1: the owner's rvalid_o=1 and rdata_o=mem_rdata_i, combinational pass-through in the same cycle; next state IDLE.
  - Non-owner rvalid stays 0. rdata outputs are 0 whenever their rvalid is 0.
- Timing:
  - Minimum occupancy 3 cycles (IDLE, REQ, RESP) with zero-latency memory.
  - Next capture happens in the cycle after rvalid; no overlap of transactions.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it equals TIMEOUT_CYC without completion: owner rvalid_o=1, rdata_o=0, err_o=1 for that single cycle, mem_req_o=0, next state IDLE.
  - A mem_rvalid_i arriving in the same cycle as the timeout wins: normal completion, err_o=0.
- Boundary rules:
  - mem_gnt_i or mem_rvalid_i outside the expected state is ignored.
  - mem_gnt_i and mem_rvalid_i in the same REQ cycle: accept the grant only; the response is expected in RESP.
  - A requester dropping req_i before its gnt is legal: no capture occurs.
  - Reset mid-transaction aborts the access with no response to the requester.
- Counter width: clog2(TIMEOUT_CYC+1) bits, no wrap.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin priority. On a tie in IDLE, grant the requester that was not the last owner. The last-owner register resets to LS, so IF wins the first tie.
- Undefined: fixed LS-over-IF priority as above; the last-owner register is not built.

Test Plan:
- IF only:
  - Stimulus: if_addr_i=0x0000_0010; memory grants immediately and returns rvalid the cycle after grant with 0x0000_0013.
  - Required: if_gnt_o in cycle 0; mem_req_o/mem_addr_o=0x10 in cycle 1; if_rvalid_o=1, if_rdata_o=0x13 in cycle 2; ls_rvalid_o=0 throughout.
- Store:
  - Stimulus: ls_we_i=1, ls_op_i=3'b000, ls_addr_i=0x100, ls_wdata_i=0xAB; mem_gnt_i delayed 3 cycles.
  - Required: mem_req_o and all fields held stable 4 cycles; ls_rvalid_o on write ack; if_gnt_o never asserts.
- Tie:
  - Stimulus: if_req_i and ls_req_i both high in IDLE.
  - Required: ls_gnt_o first. if_gnt_o in the cycle after ls_rvalid_o; with MEM_ARB_RR_EN, if_gnt_o first instead.
- Timeout:
  - Stimulus: TIMEOUT_CYC=4; grant given, no rvalid.
  - Required: 4 cycles after REQ entry, owner rvalid_o=1, rdata_o=0, err_o=1 for one cycle; busy_o=0 next cycle.
- Reset mid-access:
  - Stimulus: rst_ni=0 asynchronously while in RESP.
  - Required: mem_req_o, busy_o and all rvalid outputs 0 immediately. After release, a new if_req_i is granted normally.
- Stray inputs:
  - Stimulus: mem_rvalid_i pulses while in IDLE.
  - Required: no rvalid_o and no state change.
